// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one unified instruction/data memory between the
// CPU memory port and a debug/program-loader port. One access per clock, CPU
// wins contention, and the debug port is forced through after MAX_HOLD
// consecutive denials. Read data comes back one cycle after the grant.
// Optional performance counters are included when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Debug / loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  // Memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       dbg_force_cnt
`endif
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              dbg_force;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  assign dbg_force = (starve_cnt_q == MaxHold);

  // Grant decision and memory mux; grants are gated off while reset is low
  always_comb begin
    dbg_gnt   = reset & dbg_req & (~cpu_req | dbg_force);
    cpu_gnt   = reset & cpu_req & ~dbg_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_write = dbg_we;
      mem_read  = ~dbg_we;
    end else if (cpu_gnt) begin
      mem_write = cpu_we;
      mem_read  = ~cpu_we;
    end
  end

  // Starvation counter next state: count denied debug cycles, saturating
  always_comb begin
    starve_cnt_d = 4'd0;
    if (dbg_req && !dbg_gnt) begin
      starve_cnt_d = (starve_cnt_q >= MaxHold) ? MaxHold : starve_cnt_q + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Read return: capture memory data for the owner of a granted read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= mem_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, dbg_force_cnt_q;

  // Performance counters: contention cycles and starvation-forced debug wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt_q  <= '0;
      dbg_force_cnt_q <= '0;
    end else begin
      if (cpu_req && dbg_req) conflict_cnt_q <= conflict_cnt_q + 32'd1;
      if (cpu_req && dbg_gnt) dbg_force_cnt_q <= dbg_force_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt  = conflict_cnt_q;
  assign dbg_force_cnt = dbg_force_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-port read/write, contention with
// forced debug grants, debug request drop, and reset in flight.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt, dbg_force_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_HOLD(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_stall (cpu_stall),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .dbg_force_cnt(dbg_force_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    reset = 1'b1;
    tick();

    // CPU-only read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'h1234_5678;
    #1;
    chk("cpu_rd_gnt", {31'b0, cpu_gnt}, 32'd1);
    chk("cpu_rd_mem_read", {31'b0, mem_read}, 32'd1);
    chk("cpu_rd_mem_addr", mem_addr, 32'h10);
    chk("cpu_rd_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    cpu_req = 0; mem_rdata = 32'hAAAA_AAAA;
    #1;
    chk("cpu_rd_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    chk("cpu_rd_rdata", cpu_rdata, 32'h1234_5678);
    chk("cpu_rd_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    tick();
    chk("cpu_rd_rvalid_1cyc", {31'b0, cpu_rvalid}, 32'd0);
    chk("cpu_rd_rdata_hold", cpu_rdata, 32'h1234_5678);

    // Debug-only write
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hDEAD_BEEF;
    #1;
    chk("dbg_wr_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbg_wr_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    chk("dbg_wr_mem_write", {31'b0, mem_write}, 32'd1);
    chk("dbg_wr_mem_read", {31'b0, mem_read}, 32'd0);
    chk("dbg_wr_mem_addr", mem_addr, 32'h40);
    chk("dbg_wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    dbg_req = 0; dbg_we = 0;
    #1;
    chk("dbg_wr_no_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("dbg_wr_no_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);

    // Continuous contention: debug forced on cycles 4 and 9
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200; mem_rdata = 32'h0BAD_F00D;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("cont_dbg_gnt_c%0d", c), {31'b0, dbg_gnt},
          (c == 4 || c == 9) ? 32'd1 : 32'd0);
      chk($sformatf("cont_cpu_stall_c%0d", c), {31'b0, cpu_stall},
          (c == 4 || c == 9) ? 32'd1 : 32'd0);
      chk($sformatf("cont_mem_addr_c%0d", c), mem_addr,
          (c == 4 || c == 9) ? 32'h200 : 32'h100);
      tick();
    end
    chk("cont_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    chk("cont_dbg_rdata", dbg_rdata, 32'h0BAD_F00D);
    chk("cont_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict", conflict_cnt, 32'd10);
    chk("perf_force", dbg_force_cnt, 32'd2);
`endif

    // Debug drops on contention cycle 2, reasserts: 4 fresh denials then forced
    for (int c = 0; c < 8; c++) begin
      dbg_req = (c != 2);
      #1;
      chk($sformatf("drop_dbg_gnt_c%0d", c), {31'b0, dbg_gnt}, (c == 7) ? 32'd1 : 32'd0);
      tick();
    end

    // Build starvation to 3 while CPU reads, then reset right after the read edge
    cpu_addr = 32'h80; mem_rdata = 32'h5555_1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("pre_rst_cpu_gnt_c%0d", c), {31'b0, cpu_gnt}, 32'd1);
      tick();
    end
    reset = 1'b0;
    #1;
    chk("rst_mid_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_mid_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mid_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mid_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mid_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    chk("rst_mid_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    tick();
    chk("rst_hold_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_hold_mem_read", {31'b0, mem_read}, 32'd0);
    reset = 1'b1;

    // After release the starvation count restarts from 0: forced on 5th cycle
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("post_rst_dbg_gnt_c%0d", c), {31'b0, dbg_gnt}, (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("post_rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    chk("post_rst_dbg_rdata", dbg_rdata, 32'h5555_1111);
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict_post_rst", conflict_cnt, 32'd5);
    chk("perf_force_post_rst", dbg_force_cnt, 32'd1);
`endif
    cpu_req = 0; dbg_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
